uart_tx_buffered: RTL and testbench

//  Downstream of the command FSM: buffers single-cycle byte strobes (echo, ACK, status

---
 rtl/uart_tx_buffered.sv | 150 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Byte-strobe FIFO feeding an 8N1 LSB-first UART transmitter.
// Bytes queue while a frame is on the line; frames run back-to-back.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] txData,
  input  logic       txDataWr,
  output logic       tx,
  output logic       busy,
  output logic       fifoFull,
  output logic       fifoEmpty,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  state_t state, state_nx;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              ovf;

  logic [15:0] baud, baud_nx;
  logic [2:0]  bit_idx, bit_idx_nx;
  logic [7:0]  shift, shift_nx;
  logic        tx_nx;
  logic        pop, wr_ok, bit_end;

  assign wr_ok     = txDataWr && (count != DEPTH);
  assign bit_end   = (baud == BAUD_MAX);
  assign fifoFull  = (count == DEPTH);
  assign fifoEmpty = (count == '0);
  assign busy      = (state != IDLE) || !fifoEmpty;
  assign overflow  = ovf;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= txData;
  end

  // Space is judged on the pre-edge count: a same-cycle pop never frees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !pop)      count <= count + 1'b1;
      else if (!wr_ok && pop) count <= count - 1'b1;
      if (txDataWr && !wr_ok) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nx;
      tx      <= tx_nx;
      baud    <= baud_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tx_nx      = tx;
    baud_nx    = baud;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (!fifoEmpty) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
          tx_nx    = 1'b0;
          baud_nx  = '0;
          state_nx = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nx    = '0;
          tx_nx      = shift[0];
          shift_nx   = shift >> 1;
          bit_idx_nx = '0;
          state_nx   = DATA;
        end else begin
          baud_nx = baud + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nx = '0;
          if (bit_idx == 3'd7) begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end else begin
            tx_nx      = shift[0];
            shift_nx   = shift >> 1;
            bit_idx_nx = bit_idx + 3'd1;
          end
        end else begin
          baud_nx = baud + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nx = '0;
          // Chain straight into the next start bit with no idle gap.
          if (!fifoEmpty) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr];
            tx_nx    = 1'b0;
            state_nx = START;
          end else begin
            tx_nx    = 1'b1;
            state_nx = IDLE;
          end
        end else begin
          baud_nx = baud + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboarded bench for uart_tx_buffered: frame-level line model,
// bit-sampling receiver and per-cycle flag checks.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] txData = '0;
  logic       txDataWr = 1'b0;
  logic       tx, busy, fifoFull, fifoEmpty, overflow;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .ADDR_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .txData(txData),
    .txDataWr(txDataWr),
    .tx(tx),
    .busy(busy),
    .fifoFull(fifoFull),
    .fifoEmpty(fifoEmpty),
    .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  // Reference: byte queue plus a countdown of the frame on the line.
  logic [7:0] mq[$];
  exp_t       sb[$];
  int         timer = 0;
  logic [7:0] cur = '0;
  bit         movf = 0;
  bit         acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      sb.delete();
      timer = 0;
      movf  = 0;
    end else begin
      cyc++;
      acc = txDataWr && (mq.size() < DEPTH);
      if (txDataWr && !acc) movf = 1;
      if (timer > 0) timer--;
      if (timer == 0 && mq.size() > 0) begin
        cur   = mq.pop_front();
        timer = FRAME;
        sb.push_back('{cur, cyc});
      end
      if (acc) mq.push_back(txData);
    end
  end

  logic exp_tx;
  int   pos;

  always @(negedge clk) begin
    if (rst_n) begin
      if (timer == 0) begin
        exp_tx = 1'b1;
      end else begin
        pos = FRAME - timer;
        if (pos < CPB)           exp_tx = 1'b0;
        else if (pos >= 9 * CPB) exp_tx = 1'b1;
        else                     exp_tx = cur[pos / CPB - 1];
      end
      chk("line", tx, exp_tx);
      chk("fifoEmpty", fifoEmpty, mq.size() == 0);
      chk("fifoFull", fifoFull, mq.size() == DEPTH);
      chk("overflow", overflow, movf);
      chk("busy", busy, (timer != 0) || (mq.size() != 0));
    end
  end

  bit rx_abort = 0;
  int rx_frames = 0;

  always @(negedge rst_n) rx_abort = 1;

  task automatic rx_frame();
    logic [7:0] b;
    logic       stp;
    int         sc;
    exp_t       e;
    rx_abort = 0;
    sc = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    stp = tx;
    if (rx_abort) return;
    rx_frames++;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rx_unexpected: got frame %0h expected none", b);
      return;
    end
    e = sb.pop_front();
    chk("rx_byte", b, e.b);
    chk("rx_start_cycle", sc, e.c);
    chk("rx_stop", stp, 1'b1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) rx_frame();
    end
  end

  task automatic burst(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      txData   = first + 8'(i);
      txDataWr = 1'b1;
      @(negedge clk);
    end
    txDataWr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [9:0] pat;
  int         f0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", fifoFull, 1'b0);
    chk("rst_empty", fifoEmpty, 1'b1);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;

    // single byte, exact waveform
    @(negedge clk);
    burst(1, 8'h2A);
    @(negedge clk);
    pat = 10'b1001010100;
    for (int i = 0; i < 10; i++) begin
      chk("t1_bit", tx, pat[i]);
      repeat (CPB) @(negedge clk);
    end
    chk("t1_busy_low", busy, 1'b0);

    // three contiguous frames
    f0 = rx_frames;
    burst(3, 8'h41);
    repeat (3 * FRAME + 10) @(negedge clk);
    chk("t2_frames", rx_frames - f0, 3);
    chk("t2_ovf", overflow, 1'b0);

    // six strobes, one dropped
    f0 = rx_frames;
    burst(6, 8'hA0);
    chk("t3_full", fifoFull, 1'b1);
    chk("t3_ovf", overflow, 1'b1);
    repeat (5 * FRAME + 10) @(negedge clk);
    chk("t3_frames", rx_frames - f0, 5);
    chk("t3_full_clr", fifoFull, 1'b0);

    // write while full, same edge as a stop-end pop
    do_reset();
    burst(5, 8'h10);
    for (int i = 0; i < 100 && timer != 1; i++) @(negedge clk);
    chk("t4_wait", timer, 1);
    txData   = 8'h99;
    txDataWr = 1'b1;
    @(negedge clk);
    txDataWr = 1'b0;
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_full", fifoFull, 1'b0);
    chk("t4_empty", fifoEmpty, 1'b0);
    repeat (5 * FRAME) @(negedge clk);

    // reset mid-data
    do_reset();
    burst(3, 8'h00);
    repeat (15) @(negedge clk);
    f0 = rx_frames;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_tx", tx, 1'b1);
    chk("t5_empty", fifoEmpty, 1'b1);
    chk("t5_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    chk("t5_no_frames", rx_frames - f0, 0);

    // pointer wrap
    f0 = rx_frames;
    for (int i = 0; i < 10; i++) begin
      burst(1, 8'($urandom));
      repeat (FRAME + 4) @(negedge clk);
    end
    chk("t6_frames", rx_frames - f0, 10);

    // randomized traffic, sparse then dense
    for (int i = 0; i < 3000; i++) begin
      txData   = 8'($urandom);
      txDataWr = ($urandom_range(0, 99) < ((i < 1500) ? 3 : 15));
      @(negedge clk);
    end
    txDataWr = 1'b0;
    repeat ((DEPTH + 2) * FRAME) @(negedge clk);
    chk("drain_sb", sb.size(), 0);
    chk("drain_fifo", mq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
